piso_lane_serializer: RTL and testbench
=======================================

Name: piso_lane_serializer

Overview:
- Parametrised parallel-in/serial-out lane serializer for wide permutation states, e.g. 1600-bit Keccak state to 64-bit lanes.
- Replaces the external-count-driven shifter: an internal lane counter, valid/ready handshake on both sides, and runtime lane-count truncation for rate-limited squeeze (SHA3/SHAKE variants).
- Sits between the permutation core and the digest/output stream.

Parameters:
- STATE_W, 1600, width of the parallel input word.
- LANE_W, 64, width of each serial output lane; STATE_W % LANE_W must be 0, otherwise elaboration fails.
- MSB_FIRST, 1; 1 = lane 0 is in_data[STATE_W-1 -: LANE_W] (top first), 0 = lane 0 is in_data[LANE_W-1:0] (bottom first).
- LANE_CNT (localparam), STATE_W/LANE_W, 25 by default.
- CW (localparam), $clog2(LANE_CNT+1), width of the lane-count and index fields.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  parallel word offered
- in_ready  out  1  serializer can accept a word this cycle
- in_data  in  STATE_W  parallel word
- in_lanes  in  CW  number of lanes to emit for this word; sampled with in_data
- out_valid  out  1  out_data holds a valid lane
- out_ready  in  1  downstream accepts the lane
- out_data  out  LANE_W  current lane
- out_idx  out  CW  index of the current lane, 0-based
- out_last  out  1  current lane is the final lane of the word
- busy  out  1  a word is loaded and not fully emitted

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; shift register, out_data, out_idx and lane count all 0.
  - out_valid = 0, out_last = 0, busy = 0, in_ready = 1.
  - Reset mid-burst abandons the word; no further lanes of it are emitted.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - SHIFT: out_valid = 1, busy = 1.
- Load: on in_valid && in_ready:
  - Shift register <= in_data.
  - n <= clamp(in_lanes). in_lanes == 0 or in_lanes > LANE_CNT gives n = LANE_CNT.
  - out_idx <= 0; next state SHIFT.
  - Latency: first lane is valid the cycle after the load edge.
- Emission:
  - out_data = head lane of the shift register: upper LANE_W bits if MSB_FIRST, lower LANE_W bits otherwise.
  - out_data, out_idx and out_last must stay stable while out_valid && !out_ready.
- On out_valid && out_ready:
  - Shift register moves by LANE_W toward the head (left if MSB_FIRST, right otherwise) with zero fill.
  - out_idx increments.
- out_last = out_valid && (out_idx == n-1).
- Completion: on the out_last beat accepted:
  - If in_valid is also high, the new word loads on the same edge (in_ready is also high on this beat) and the state stays SHIFT. No bubble.
  - Otherwise the state goes to IDLE.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last).
  - This is combinational from out_ready. It is the only combinational in-to-out path.
- in_valid while busy and not on the last accepted beat: ignored; in_data is not sampled.
- Lanes at index >= n are never emitted; they are discarded on the next load.
- Throughput: one lane per cycle with out_ready held high. n cycles per word, back-to-back.

Test Plan:
- Full word, MSB_FIRST=1:
  - Stimulus: lane k (from the top) = 64'h0000_0000_0000_00kk, in_lanes = 25, out_ready = 1.
  - Required: 25 consecutive beats, out_data = k, out_idx = k; out_last only at idx 24; in_ready low for idx 0..23, high at idx 24; busy low afterwards.
- Truncation:
  - Stimulus: in_lanes = 17 (SHA3-256 rate).
  - Required: exactly 17 beats, last at idx 16 with out_data = 16; lane values 17..24 never appear.
  - Repeat with in_lanes = 0 and in_lanes = 30: each gives 25 beats.
- Backpressure:
  - Stimulus: out_ready pattern 1,0,0,1,0,1,... across a 25-lane word.
  - Required: out_data and out_idx held constant on every stall cycle; the full ordered sequence 0..24 is delivered with no loss or duplication.
- Back-to-back words:
  - Stimulus: word A (in_lanes = 3, lanes 0xA0..0xA2) and word B (in_lanes = 2, lanes 0xB0..0xB1); B is presented with in_valid high during A's last beat.
  - Required: beats A0,A1,A2,B0,B1 on 5 consecutive cycles with no gap; out_last on A2 and on B1.
- MSB_FIRST=0 build:
  - Stimulus: in_data[64k+63:64k] = k, in_lanes = 25.
  - Required: out_data sequence 0..24 with lane 0 taken from the bottom bits.
- Reset mid-burst:
  - Stimulus: assert rst_n low asynchronously at idx 10.
  - Required: out_valid = 0, busy = 0, out_data = 0 immediately, without waiting for a clock edge.
  - After release: in_ready = 1; a new word starts at idx 0 and no lanes of the old word appear.

Source files
------------

// File: rtl/piso_lane_serializer.sv
// Parallel-in/serial-out lane serializer: loads a wide state word and emits it
// lane by lane over a valid/ready stream, with runtime lane-count truncation.
//
// state | meaning
// IDLE  | no word held; in_ready high, waiting for a parallel word
// SHIFT | word loaded; head lane presented on out_data until the last lane is taken
module piso_lane_serializer #(
    parameter int STATE_W   = 1600,
    parameter int LANE_W    = 64,
    parameter bit MSB_FIRST = 1'b1,
    localparam int LANE_CNT = STATE_W / LANE_W,
    localparam int CW       = $clog2(LANE_CNT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic [CW-1:0]      in_lanes,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANE_W-1:0]  out_data,
    output logic [CW-1:0]      out_idx,
    output logic               out_last,
    output logic               busy
);

    if (STATE_W % LANE_W != 0) begin : g_bad_width
        $error("piso_lane_serializer: STATE_W must be a multiple of LANE_W");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [STATE_W-1:0] sreg;
    logic [STATE_W-1:0] sreg_shifted;
    logic [CW-1:0]      idx;
    logic [CW-1:0]      n;
    logic [CW-1:0]      lanes_clamped;
    logic               accept;
    logic               load;

    assign out_valid = (state == SHIFT);
    assign busy      = (state == SHIFT);
    assign out_idx   = idx;
    assign out_last  = out_valid && (idx == n - CW'(1));
    assign accept    = out_valid && out_ready;

    // The last accepted beat frees the register on the same edge, so a waiting
    // word can load with no bubble; this is the only out_ready -> in_ready path.
    assign in_ready  = (state == IDLE) || (accept && out_last);
    assign load      = in_valid && in_ready;

    assign lanes_clamped = ((in_lanes == '0) || (in_lanes > CW'(LANE_CNT)))
                           ? CW'(LANE_CNT) : in_lanes;

    if (MSB_FIRST) begin : g_msb
        assign out_data     = sreg[STATE_W-1 -: LANE_W];
        assign sreg_shifted = sreg << LANE_W;
    end else begin : g_lsb
        assign out_data     = sreg[LANE_W-1:0];
        assign sreg_shifted = sreg >> LANE_W;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (accept && out_last) begin
                    state_next = load ? SHIFT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            idx  <= '0;
            n    <= '0;
        end else if (load) begin
            sreg <= in_data;
            idx  <= '0;
            n    <= lanes_clamped;
        end else if (accept) begin
            sreg <= sreg_shifted;
            idx  <= idx + CW'(1);
        end
    end

endmodule

// File: tb/tb_piso_lane_serializer.sv
// Directed bench for piso_lane_serializer: MSB-first instance for most scenarios,
// plus an LSB-first instance for bottom-first lane ordering.
module tb_piso_lane_serializer;

    localparam int SW = 1600;
    localparam int LW = 64;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          in_valid = 1'b0, in_ready;
    logic [SW-1:0] in_data = '0;
    logic [CW-1:0] in_lanes = '0;
    logic          out_valid, out_ready = 1'b0, out_last, busy;
    logic [LW-1:0] out_data;
    logic [CW-1:0] out_idx;

    logic          l_in_valid = 1'b0, l_in_ready;
    logic [SW-1:0] l_in_data = '0;
    logic [CW-1:0] l_in_lanes = '0;
    logic          l_out_valid, l_out_ready = 1'b0, l_out_last, l_busy;
    logic [LW-1:0] l_out_data;
    logic [CW-1:0] l_out_idx;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    piso_lane_serializer #(.STATE_W(SW), .LANE_W(LW), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_lanes(in_lanes),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    piso_lane_serializer #(.STATE_W(SW), .LANE_W(LW), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data), .in_lanes(l_in_lanes),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data),
        .out_idx(l_out_idx), .out_last(l_out_last), .busy(l_busy)
    );

    // Lane k holds base+k; msb selects whether lane 0 sits at the top or bottom.
    function automatic logic [SW-1:0] build_word(input logic [63:0] base, input bit msb);
        logic [SW-1:0] w;
        w = '0;
        for (int k = 0; k < 25; k++) begin
            if (msb) w[SW-1-64*k -: 64] = base + 64'(k);
            else     w[64*k +: 64]      = base + 64'(k);
        end
        return w;
    endfunction

    // Presents a word on the MSB-first instance; returns at posedge+1 after the load edge.
    task automatic do_load(input logic [SW-1:0] w, input logic [CW-1:0] lanes);
        int cyc;
        cyc = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = w; in_lanes = lanes; out_ready = 1'b0;
        #1;
        while (!in_ready && cyc < 40) begin
            @(posedge clk); #2;
            cyc++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [72:0] obs, exp;
        #3;
        obs = {out_valid, out_data, out_idx, out_last, in_ready, busy};
        exp = {1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, exp);
        end
        vectors++;
        if ({l_out_valid, l_in_ready, l_busy} !== 3'b010) begin
            errors++;
            $display("FAIL reset_state_lsb: got %b want 010", {l_out_valid, l_in_ready, l_busy});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Streams one word with out_ready high; checks every beat and the idle state after.
    task automatic run_full(input string name, input logic [63:0] base, input int nexp);
        logic [72:0] obs, exp;
        int k, cyc;
        k = 0; cyc = 0;
        out_ready = 1'b1; #1;
        while (k < nexp && cyc < 100) begin
            exp = {1'b1, base + 64'(k), 5'(k), (k == nexp-1), (k == nexp-1), 1'b1};
            obs = {out_valid, out_data, out_idx, out_last, in_ready, busy};
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s beat %0d: got %h want %h", name, k, obs, exp);
            end
            k++; cyc++;
            @(posedge clk); #1; out_ready = 1'b1; #1;
        end
        vectors++;
        if ({out_valid, out_last, in_ready, busy} !== 4'b0010) begin
            errors++;
            $display("FAIL %s idle_after: got %b want 0010", name, {out_valid, out_last, in_ready, busy});
        end
    endtask

    task automatic test_full_word();
        do_load(build_word(64'd0, 1'b1), 5'd25);
        run_full("full_word", 64'd0, 25);
    endtask

    task automatic test_truncation();
        do_load(build_word(64'd0, 1'b1), 5'd17);
        run_full("trunc17", 64'd0, 17);
        do_load(build_word(64'h100, 1'b1), 5'd0);
        run_full("trunc0", 64'h100, 25);
        do_load(build_word(64'h200, 1'b1), 5'd30);
        run_full("trunc30", 64'h200, 25);
    endtask

    task automatic test_backpressure();
        logic [72:0] obs, exp;
        logic        pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int k, cyc;
        do_load(build_word(64'd0, 1'b1), 5'd25);
        k = 0; cyc = 0;
        out_ready = pat[0]; #1;
        while (k < 25 && cyc < 200) begin
            exp = {1'b1, 64'(k), 5'(k), (k == 24), (out_ready && k == 24), 1'b1};
            obs = {out_valid, out_data, out_idx, out_last, in_ready, busy};
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL backpressure cyc %0d lane %0d: got %h want %h", cyc, k, obs, exp);
            end
            if (out_ready) k++;
            cyc++;
            @(posedge clk); #1; out_ready = pat[cyc % 6]; #1;
        end
        vectors++;
        if (k != 25 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_done: lanes=%0d out_valid=%b want 25/0", k, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [72:0] obs, exp;
        logic [63:0] e_data [5] = '{64'hA0, 64'hA1, 64'hA2, 64'hB0, 64'hB1};
        logic [4:0]  e_idx  [5] = '{5'd0, 5'd1, 5'd2, 5'd0, 5'd1};
        logic        e_last [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_load(build_word(64'hA0, 1'b1), 5'd3);
        // B is offered from A's first beat; it must be ignored until A's last beat.
        in_valid = 1'b1; in_data = build_word(64'hB0, 1'b1); in_lanes = 5'd2;
        out_ready = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            exp = {1'b1, e_data[i], e_idx[i], e_last[i], e_last[i], 1'b1};
            obs = {out_valid, out_data, out_idx, out_last, in_ready, busy};
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back beat %0d: got %h want %h", i, obs, exp);
            end
            @(posedge clk); #1;
            if (i == 2) in_valid = 1'b0;
            #1;
        end
        vectors++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL back_to_back_idle: got %b want 001", {out_valid, busy, in_ready});
        end
    endtask

    task automatic test_lsb_first();
        logic [72:0] obs, exp;
        int k, cyc;
        @(posedge clk); #1;
        l_in_valid = 1'b1; l_in_data = build_word(64'd0, 1'b0); l_in_lanes = 5'd25;
        @(posedge clk); #1;
        l_in_valid = 1'b0; l_out_ready = 1'b1; #1;
        k = 0; cyc = 0;
        while (k < 25 && cyc < 100) begin
            exp = {1'b1, 64'(k), 5'(k), (k == 24), (k == 24), 1'b1};
            obs = {l_out_valid, l_out_data, l_out_idx, l_out_last, l_in_ready, l_busy};
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lsb_first beat %0d: got %h want %h", k, obs, exp);
            end
            k++; cyc++;
            @(posedge clk); #2;
        end
        vectors++;
        if ({l_out_valid, l_busy, l_in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL lsb_first_idle: got %b want 001", {l_out_valid, l_busy, l_in_ready});
        end
        l_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [72:0] obs, exp;
        int k;
        do_load(build_word(64'h40, 1'b1), 5'd25);
        out_ready = 1'b1; #1;
        k = 0;
        while (k < 10 && out_idx != 5'd10) begin
            @(posedge clk); #2;
            k++;
        end
        vectors++;
        if (out_idx !== 5'd10 || out_data !== 64'h4A) begin
            errors++;
            $display("FAIL mid_burst_reach: idx=%0d data=%h want 10/4a", out_idx, out_data);
        end
        rst_n = 1'b0;
        #1;
        obs = {out_valid, out_data, out_idx, out_last, in_ready, busy};
        exp = {1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", obs, exp);
        end
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL after_reset: got %b want 10", {in_ready, out_valid});
        end
        do_load(build_word(64'h80, 1'b1), 5'd25);
        run_full("post_reset_word", 64'h80, 25);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_word();
        test_truncation();
        test_backpressure();
        test_back_to_back();
        test_lsb_first();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
